// File: rtl/mem_pkg.sv
// Shared types and sizes for the memory responder and its byte store.
package mem_pkg;

  localparam int MEM_DEPTH  = 512;
  localparam int MEM_ADDR_W = 9;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  // Bytes moved for a dataSize code; the reserved code 11 behaves as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// 512x8 byte store with four byte-lane ports; lane k sits at (addr_i + k) mod 512.
module mem_byte_array
  import mem_pkg::*;
(
  input  logic                  clk_i,
  input  logic [MEM_ADDR_W-1:0] addr_i,
  input  logic [3:0]            we_i,
  input  logic [3:0][7:0]       wdata_i,
  output logic [3:0][7:0]       rdata_o
);

  logic [7:0]                  mem_q [MEM_DEPTH];
  logic [3:0][MEM_ADDR_W-1:0]  lane_addr;

  // Address addition wraps at 9 bits, which gives the modulo-512 behaviour.
  always_comb begin
    for (int k = 0; k < 4; k++) lane_addr[k] = addr_i + MEM_ADDR_W'(k);
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 4; k++) begin
      if (we_i[k]) mem_q[lane_addr[k]] <= wdata_i[k];
      rdata_o[k] <= mem_q[lane_addr[k]];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Responder side of the MFA/MFC memory handshake with programmable wait states.
// Optional alignment checking is compiled in with MEM_ALIGN_CHECK_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int WAIT_STATES = 2
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  memFuncActive,
  input  logic                  readWrite,
  input  logic [MEM_ADDR_W-1:0] address,
  input  logic [1:0]            dataSize,
  input  logic [31:0]           dataIn,
  output logic [31:0]           dataOut,
  output logic                  memFuncComplete,
  output logic                  memError
);

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic [MEM_ADDR_W-1:0]   addr_q;
  logic                    rw_q;
  logic [1:0]              size_q;
  logic [31:0]             din_q;
  logic [31:0]             dout_q;
  logic                    mfc_q;
  logic                    err_q;

  logic [2:0]              nbytes;
  logic [5:0]              shamt;
  logic                    misalign_d;
  logic                    access_d;
  logic [MEM_ADDR_W-1:0]   arr_addr;
  logic [3:0]              lane_we;
  logic [3:0][7:0]         lane_wdata;
  logic [3:0][7:0]         lane_rdata;
  logic [31:0]             wshift;
  logic [31:0]             dout_d;

  assign nbytes = size_bytes(size_q);
  assign shamt  = {3'd4 - nbytes, 3'b000};

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_d = ((size_q == SIZE_HALF) && addr_q[0]) ||
                      (size_q[1] && (addr_q[1:0] != 2'b00));
`else
  assign misalign_d = 1'b0;
`endif

  assign access_d = (state_q == BUSY) && memFuncActive && (cnt_q == 4'd0) && !reset;

  // The read port is registered, so while idle it looks at the live address;
  // the latching edge then already holds the requested bytes.
  assign arr_addr = (state_q == IDLE) ? address : addr_q;

  // Lane 0 carries the most significant byte of the access.
  assign wshift = din_q << shamt;
  assign dout_d = {lane_rdata[0], lane_rdata[1], lane_rdata[2], lane_rdata[3]} >> shamt;

  always_comb begin
    lane_we = '0;
    for (int k = 0; k < 4; k++) begin
      lane_wdata[k] = wshift[31-8*k -: 8];
      if (access_d && !rw_q && !misalign_d && (3'(k) < nbytes)) lane_we[k] = 1'b1;
    end
  end

  mem_byte_array u_array (
    .clk_i   (Clk),
    .addr_i  (arr_addr),
    .we_i    (lane_we),
    .wdata_i (lane_wdata),
    .rdata_o (lane_rdata)
  );

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      size_q  <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      mfc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (memFuncActive) begin
            addr_q  <= address;
            rw_q    <= readWrite;
            size_q  <= dataSize;
            din_q   <= dataIn;
            cnt_q   <= 4'(WAIT_STATES);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (!memFuncActive) begin
            state_q <= IDLE;
          end else if (cnt_q == 4'd0) begin
            state_q <= DONE;
            mfc_q   <= 1'b1;
            err_q   <= misalign_d;
            if (misalign_d)  dout_q <= '0;
            else if (rw_q)   dout_q <= dout_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          if (!memFuncActive) begin
            state_q <= IDLE;
            mfc_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dataOut         = dout_q;
  assign memFuncComplete = mfc_q;
  assign memError        = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder against a byte-array reference model.
module tb_mem_responder;

  localparam int W = 2;

  logic        Clk = 1'b0;
  logic        reset, memFuncActive, readWrite;
  logic [8:0]  address;
  logic [1:0]  dataSize;
  logic [31:0] dataIn, dataOut;
  logic        memFuncComplete, memError;

  int total = 0;
  int bad   = 0;
  logic [7:0] ref_mem [512];

  always #5 Clk = ~Clk;

  mem_responder #(.WAIT_STATES(W)) dut (
    .Clk(Clk), .reset(reset), .memFuncActive(memFuncActive), .readWrite(readWrite),
    .address(address), .dataSize(dataSize), .dataIn(dataIn), .dataOut(dataOut),
    .memFuncComplete(memFuncComplete), .memError(memError)
  );

  function automatic int nb(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic mis(input logic [8:0] a, input logic [1:0] s);
`ifdef MEM_ALIGN_CHECK_EN
    return (s == 2'b01 && a[0]) || (s[1] && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_read(input logic [8:0] a, input logic [1:0] s);
    logic [31:0] v = 0;
    if (mis(a, s)) return 0;
    for (int k = 0; k < nb(s); k++) v = {v[23:0], ref_mem[(int'(a) + k) % 512]};
    return v;
  endfunction

  task automatic ref_write(input logic [8:0] a, input logic [1:0] s, input logic [31:0] d);
    int n = nb(s);
    if (mis(a, s)) return;
    for (int k = 0; k < n; k++) ref_mem[(int'(a) + k) % 512] = 8'(d >> (8 * (n - 1 - k)));
  endtask

  // All helpers are entered and left at a negative clock edge.
  task automatic start(input logic rw, input logic [8:0] a, input logic [1:0] s, input logic [31:0] d);
    memFuncActive = 1'b1; readWrite = rw; address = a; dataSize = s; dataIn = d;
  endtask

  task automatic wait_mfc(input string nm);
    int e = 0;
    do begin
      @(posedge Clk); e++;
      @(negedge Clk);
      if (e == 1) begin
        address = 9'($urandom); dataIn = $urandom; dataSize = 2'($urandom); readWrite = 1'($urandom);
      end
    end while (!memFuncComplete && e < 40);
    total++;
    if (e !== W + 2) begin
      bad++; $display("FAIL %s latency: got %0d edges, want %0d", nm, e, W + 2);
    end
  endtask

  task automatic drop_mfa(input string nm);
    memFuncActive = 1'b0;
    @(posedge Clk); @(negedge Clk);
    total++;
    if (memFuncComplete !== 1'b0) begin
      bad++; $display("FAIL %s mfc_fall: got %b want 0", nm, memFuncComplete);
    end
  endtask

  task automatic run(input string nm, input logic rw, input logic [8:0] a, input logic [1:0] s, input logic [31:0] d);
    logic [31:0] exp_d = ref_read(a, s);
    logic        exp_e = mis(a, s);
    start(rw, a, s, d);
    wait_mfc(nm);
    total++;
    if (memError !== exp_e) begin
      bad++; $display("FAIL %s memError: got %b want %b", nm, memError, exp_e);
    end
    if (rw || exp_e) begin
      total++;
      if (dataOut !== exp_d) begin
        bad++; $display("FAIL %s dataOut: got %h want %h", nm, dataOut, exp_d);
      end
    end
    if (!rw) ref_write(a, s, d);
    drop_mfa(nm);
  endtask

  task automatic expect_const(input string nm, input logic [31:0] want);
    total++;
    if (dataOut !== want) begin
      bad++; $display("FAIL %s: got %h want %h", nm, dataOut, want);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; memFuncActive = 1'b0; readWrite = 1'b0; address = '0; dataSize = '0; dataIn = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    total += 3;
    if (dataOut !== 32'h0)        begin bad++; $display("FAIL reset dataOut: got %h want 0", dataOut); end
    if (memFuncComplete !== 1'b0) begin bad++; $display("FAIL reset mfc: got %b want 0", memFuncComplete); end
    if (memError !== 1'b0)        begin bad++; $display("FAIL reset memError: got %b want 0", memError); end
    reset = 1'b0;
  endtask

  task automatic test_fill;
    for (int i = 0; i < 128; i++) run("fill", 1'b0, 9'(i * 4), 2'b10, $urandom);
  endtask

  task automatic test_plan;
    run("w_deadbeef", 1'b0, 9'h010, 2'b10, 32'hDEADBEEF);
    run("r_word", 1'b1, 9'h010, 2'b10, 0);  expect_const("plan_word", 32'hDEADBEEF);
    run("r_byte", 1'b1, 9'h011, 2'b00, 0);  expect_const("plan_byte", 32'h000000AD);
    run("r_half", 1'b1, 9'h012, 2'b01, 0);  expect_const("plan_half", 32'h0000BEEF);
    run("r_b10", 1'b1, 9'h010, 2'b00, 0);   expect_const("plan_b10", 32'h000000DE);
    run("r_b13", 1'b1, 9'h013, 2'b00, 0);   expect_const("plan_b13", 32'h000000EF);
  endtask

  task automatic test_abort;
    start(1'b0, 9'h020, 2'b10, 32'h11223344);
    @(posedge Clk); @(posedge Clk); @(negedge Clk);
    memFuncActive = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); @(negedge Clk);
      total++;
      if (memFuncComplete !== 1'b0) begin bad++; $display("FAIL abort mfc: got %b want 0", memFuncComplete); end
    end
    run("abort_read", 1'b1, 9'h020, 2'b10, 0);
  endtask

  task automatic test_reset_busy;
    start(1'b0, 9'h030, 2'b10, 32'h55667788);
    @(posedge Clk); @(posedge Clk); @(negedge Clk);
    reset = 1'b1; memFuncActive = 1'b0;
    @(posedge Clk); @(negedge Clk);
    reset = 1'b0;
    run("rst_busy_read", 1'b1, 9'h030, 2'b10, 0);
  endtask

  task automatic test_reset_done;
    start(1'b1, 9'h010, 2'b10, 0);
    wait_mfc("rst_done");
    reset = 1'b1; memFuncActive = 1'b0;
    @(posedge Clk); @(negedge Clk);
    reset = 1'b0;
    total += 2;
    if (memFuncComplete !== 1'b0) begin bad++; $display("FAIL rst_done mfc: got %b want 0", memFuncComplete); end
    if (dataOut !== 32'h0)        begin bad++; $display("FAIL rst_done dataOut: got %h want 0", dataOut); end
    run("rst_done_read", 1'b1, 9'h010, 2'b10, 0);
    expect_const("rst_done_keep", 32'hDEADBEEF);
  endtask

  task automatic test_misalign;
`ifdef MEM_ALIGN_CHECK_EN
    logic [31:0] before = ref_read(9'h013, 2'b00);
    run("mis_write", 1'b0, 9'h013, 2'b10, 32'hCAFEBABE);
    total++;
    if (memError !== 1'b1) begin bad++; $display("FAIL mis_err: got %b want 1", memError); end
    run("mis_b13", 1'b1, 9'h013, 2'b00, 0);
    expect_const("mis_b13_keep", before);
    run("mis_b14", 1'b1, 9'h014, 2'b00, 0);
    run("mis_b16", 1'b1, 9'h016, 2'b00, 0);
    run("mis_half", 1'b1, 9'h011, 2'b01, 0);
`else
    run("wrap_write", 1'b0, 9'h1FF, 2'b10, 32'hA1B2C3D4);
    run("wrap_read", 1'b1, 9'h1FF, 2'b10, 0);  expect_const("wrap_word", 32'hA1B2C3D4);
    run("wrap_b000", 1'b1, 9'h000, 2'b00, 0);  expect_const("wrap_b000", 32'h000000B2);
    run("wrap_b1ff", 1'b1, 9'h1FF, 2'b00, 0);  expect_const("wrap_b1ff", 32'h000000A1);
`endif
  endtask

  task automatic test_hold_done;
    logic [31:0] exp_d = ref_read(9'h010, 2'b10);
    start(1'b1, 9'h010, 2'b10, 0);
    wait_mfc("hold");
    for (int i = 0; i < 5; i++) begin
      readWrite = 1'b0; address = 9'h010; dataSize = 2'b10; dataIn = $urandom;
      @(posedge Clk); @(negedge Clk);
      total += 2;
      if (memFuncComplete !== 1'b1) begin bad++; $display("FAIL hold mfc: got %b want 1", memFuncComplete); end
      if (dataOut !== exp_d)        begin bad++; $display("FAIL hold dataOut: got %h want %h", dataOut, exp_d); end
    end
    drop_mfa("hold");
    run("hold_again", 1'b1, 9'h010, 2'b10, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 80; i++)
      run("rand", 1'($urandom), 9'($urandom), 2'($urandom_range(0, 3)), $urandom);
  endtask

  initial begin
    @(negedge Clk);
    test_reset;
    test_fill;
    test_plan;
    test_abort;
    test_reset_busy;
    test_reset_done;
    test_misalign;
    test_hold_done;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Responder end of the datapath memory handshake: services MFA/RW/address/dataSize requests issued by the control unit and answers with MFC and read data. It holds a 512-byte, byte-addressable, big-endian store and inserts a programmable number of wait states. It sits where the datapath's RAM address mux and MDR connect.

## Interface
- WAIT_STATES, default 2: busy cycles inserted before MFC; range 0–15.
- Clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- memFuncActive  in  1  MFA request from the initiator; held high through the transaction.
- readWrite  in  1  1 = read, 0 = write.
- address  in  9  byte address of the most significant byte.
- dataSize  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- dataIn  in  32  write data, right-justified.
- dataOut  out  32  read data, right-justified, zero-extended.
- memFuncComplete  out  1  MFC.
- memError  out  1  misaligned-access flag, valid with MFC.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if MFA is sampled high, latch address/RW/dataSize/dataIn, load the counter with WAIT_STATES, and go to BUSY.
- BUSY:
  - If MFA is sampled low, abort to IDLE. No write occurs and MFC never rises.
  - Else if the counter is 0, perform the access and go to DONE.
  - Else decrement the counter.
- Access on the BUSY→DONE edge:
  - Write: store dataIn[8n-1:0] big-endian at address..address+n-1, where n is 1, 2 or 4.
  - Read: load dataOut with the same bytes, zero-extended into the low bits.
- DONE: MFC = 1 and dataOut is held. When MFA is sampled low, go to IDLE with MFC = 0. Changes to inputs while in DONE are ignored.
- Address arithmetic is modulo 512: a word at 0x1FF uses bytes 0x1FF, 0x000, 0x001, 0x002 (only when alignment checking is compiled out).
- Back-to-back requests: MFA must be sampled low at least once, which returns the FSM to IDLE. Its next sampled high starts a new transaction.
- Reset:
  - State returns to IDLE; dataOut = 0, memFuncComplete = 0, memError = 0, counter = 0.
  - The memory array is not cleared.
  - Reset asserted mid-BUSY cancels the pending write.
  - Reset wins over every other event in the same cycle.

## Timing
- MFA sampled at edge t: MFC is high after edge t + WAIT_STATES + 1. With WAIT_STATES = 0, MFC is high after edge t+1.
- dataOut and memError are registered and change only on the BUSY→DONE edge or on reset. They are stable for the whole time MFC is high.
- MFC falls one edge after MFA is sampled low.
- Write data becomes visible to a following read at its own DONE edge. No read-during-write hazard exists because there is one transaction at a time.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - A halfword with address[0] = 1, or a word with address[1:0] ≠ 00, completes normally with MFC.
  - In that case memError = 1, dataOut = 0, and the write is suppressed.
  - Aligned accesses give memError = 0.
- MEM_ALIGN_CHECK_EN undefined: no alignment check; memError is tied to 0; misaligned accesses proceed with modulo-512 byte addressing.

## Structure
- Shared package mem_pkg:
  - dataSize encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD.
  - FSM state type.
  - MEM_DEPTH = 512 and MEM_ADDR_W = 9.
- One sub-module, mem_byte_array: 512×8 storage with four byte-lane ports.
  - Lane k addresses (address + k) mod 512.
  - Per-lane write enable; registered read.
- The top level holds the FSM, counter, lane steering, and the alignment check.

## Test plan
- WAIT_STATES = 2: word write 0xDEADBEEF at 0x010, then word read at 0x010 → MFC high 3 cycles after MFA; dataOut = 0xDEADBEEF; bytes 0x010..0x013 = DE, AD, BE, EF.
- Byte read at 0x011 after the above → dataOut = 0x000000AD. Halfword read at 0x012 → 0x0000BEEF.
- MFA dropped after 1 BUSY cycle of a word write 0x11223344 to 0x020 → MFC never rises; a subsequent read of 0x020 returns the old contents.
- Reset asserted while in DONE → next cycle MFC = 0, dataOut = 0; a read of the earlier data still returns 0xDEADBEEF.
- MEM_ALIGN_CHECK_EN, word write 0xCAFEBABE at 0x013 → MFC with memError = 1; bytes 0x013..0x016 unchanged. Without the macro, a word read at 0x1FF after writing 0xA1B2C3D4 there → 0xA1B2C3D4 via wrap.
- Hold MFA high in DONE for 5 cycles → MFC remains 1 and no second access occurs. Drop MFA for 1 cycle then raise → a new transaction completes after WAIT_STATES + 1 edges.
